// File: rtl/img_of_integrator.sv
// img_of_integrator - applies a deadband to per-frame flow, then integrates it into saturating positions.
// Results leave on a valid/ready port; samples that arrive while that port is stalled are counted as dropped.
module img_of_integrator #(
  parameter int DX_BITS    = 32,
  parameter int DY_BITS    = 32,
  parameter int POS_BITS   = 40,
  parameter int FRAME_BITS = 16,
  parameter int DROP_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cke,
  input  logic                         in_clear,
  input  logic        [DX_BITS-1:0]    param_deadband,
  input  logic signed [DX_BITS-1:0]    s_of_dx,
  input  logic signed [DY_BITS-1:0]    s_of_dy,
  input  logic                         s_of_valid,
  output logic signed [POS_BITS-1:0]   m_pos_x,
  output logic signed [POS_BITS-1:0]   m_pos_y,
  output logic        [FRAME_BITS-1:0] m_frame,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic        [DROP_BITS-1:0]  out_drop_count
);

  localparam int W = ((DX_BITS > DY_BITS) ? DX_BITS : DY_BITS) + 1;
  localparam logic signed [POS_BITS-1:0] POS_MAX = {1'b0, {(POS_BITS-1){1'b1}}};
  localparam logic signed [POS_BITS-1:0] POS_MIN = {1'b1, {(POS_BITS-1){1'b0}}};

  logic        [DX_BITS:0]      mag_x;
  logic        [DY_BITS:0]      mag_y;
  logic        [W-1:0]          db_w;
  logic signed [DX_BITS-1:0]    dz_x, s1_dx;
  logic signed [DY_BITS-1:0]    dz_y, s1_dy;
  logic                         s1_valid;
  logic signed [POS_BITS-1:0]   acc_x, acc_y, nx_x, nx_y;
  logic        [FRAME_BITS-1:0] frame, nx_frame;
  logic                         dirty;

  function automatic logic signed [POS_BITS-1:0] sat_add(
    input logic signed [POS_BITS-1:0] p,
    input logic signed [POS_BITS:0]   d
  );
    logic signed [POS_BITS:0] sum;
    sum = {p[POS_BITS-1], p} + d;
    if (sum[POS_BITS] != sum[POS_BITS-1])
      return sum[POS_BITS] ? POS_MIN : POS_MAX;
    return sum[POS_BITS-1:0];
  endfunction

  // Magnitudes are one bit wider so the most-negative input has an exact absolute value.
  always_comb begin
    mag_x = s_of_dx[DX_BITS-1] ? -{s_of_dx[DX_BITS-1], s_of_dx} : {s_of_dx[DX_BITS-1], s_of_dx};
    mag_y = s_of_dy[DY_BITS-1] ? -{s_of_dy[DY_BITS-1], s_of_dy} : {s_of_dy[DY_BITS-1], s_of_dy};
    db_w  = W'(param_deadband);
    dz_x  = (W'(mag_x) < db_w) ? '0 : s_of_dx;
    dz_y  = (W'(mag_y) < db_w) ? '0 : s_of_dy;
  end

  always_comb begin
    nx_x     = sat_add(acc_x, (POS_BITS+1)'(s1_dx));
    nx_y     = sat_add(acc_y, (POS_BITS+1)'(s1_dy));
    nx_frame = frame + FRAME_BITS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_dx          <= '0;
      s1_dy          <= '0;
      acc_x          <= '0;
      acc_y          <= '0;
      frame          <= '0;
      dirty          <= 1'b0;
      m_pos_x        <= '0;
      m_pos_y        <= '0;
      m_frame        <= '0;
      m_valid        <= 1'b0;
      out_drop_count <= '0;
    end else if (cke) begin
      s1_valid <= s_of_valid;
      s1_dx    <= dz_x;
      s1_dy    <= dz_y;
      if (in_clear) begin
        // The sample already in S1 is discarded; the one entering S1 now survives the clear.
        acc_x          <= '0;
        acc_y          <= '0;
        frame          <= '0;
        dirty          <= 1'b0;
        m_valid        <= 1'b0;
        out_drop_count <= '0;
      end else if (s1_valid) begin
        acc_x <= nx_x;
        acc_y <= nx_y;
        frame <= nx_frame;
        if (!m_valid || m_ready) begin
          m_pos_x <= nx_x;
          m_pos_y <= nx_y;
          m_frame <= nx_frame;
          m_valid <= 1'b1;
          dirty   <= 1'b0;
        end else begin
          dirty <= 1'b1;
          if (out_drop_count != '1)
            out_drop_count <= out_drop_count + DROP_BITS'(1);
        end
      end else if (m_valid && m_ready) begin
        // After a stall, the handshake is followed by the newest accumulator value.
        if (dirty) begin
          m_pos_x <= acc_x;
          m_pos_y <= acc_y;
          m_frame <= frame;
          dirty   <= 1'b0;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_img_of_integrator.sv
// tb_img_of_integrator - directed vector table plus hand-written stall, clear, cke and reset sequences.
module tb_img_of_integrator;

  logic               clk = 1'b0;
  logic               reset, cke, in_clear, s_of_valid, m_ready, m_valid;
  logic        [31:0] param_deadband;
  logic signed [31:0] s_of_dx, s_of_dy;
  logic signed [39:0] m_pos_x, m_pos_y;
  logic        [15:0] m_frame, out_drop_count;

  int total = 0;
  int bad   = 0;

  localparam longint PMAX = 64'sd549755813887;

  img_of_integrator dut (
    .clk(clk), .reset(reset), .cke(cke), .in_clear(in_clear),
    .param_deadband(param_deadband), .s_of_dx(s_of_dx), .s_of_dy(s_of_dy),
    .s_of_valid(s_of_valid), .m_pos_x(m_pos_x), .m_pos_y(m_pos_y), .m_frame(m_frame),
    .m_valid(m_valid), .m_ready(m_ready), .out_drop_count(out_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [31:0] db;
    logic [31:0] dx;
    logic [31:0] dy;
    longint      ex;
    longint      ey;
    int          ef;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] dx, input logic [31:0] dy);
    s_of_valid = 1'b1;
    s_of_dx    = dx;
    s_of_dy    = dy;
    @(negedge clk);
    s_of_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    in_clear = 1'b1;
    @(negedge clk);
    in_clear = 1'b0;
  endtask

  task automatic burst(input int n, input logic [31:0] dx);
    s_of_valid = 1'b1;
    s_of_dx    = dx;
    s_of_dy    = '0;
    repeat (n) @(negedge clk);
    s_of_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd0,  32'd100, -32'sd50, 100, -50, 1};
    vecs[1] = '{1'b0, 32'd0,  32'd20,  32'd5,    120, -45, 2};
    vecs[2] = '{1'b1, 32'd16, 32'd15,  -32'sd16, 0,   -16, 1};
    vecs[3] = '{1'b0, 32'd16, -32'sd15, 32'd16,  0,   0,   2};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001, -64'sd2147483648, 0, 1};

    reset = 1'b1; cke = 1'b1; in_clear = 1'b0; s_of_valid = 1'b0; m_ready = 1'b1;
    param_deadband = '0; s_of_dx = '0; s_of_dy = '0;
    #1;
    chk("reset_pos_x", m_pos_x, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_drop", out_drop_count, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].clr) pulse_clear();
      param_deadband = vecs[i].db;
      send(vecs[i].dx, vecs[i].dy);
      chk($sformatf("vec%0d_x", i), m_pos_x, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), m_pos_y, vecs[i].ey);
      chk($sformatf("vec%0d_frame", i), m_frame, vecs[i].ef);
      chk($sformatf("vec%0d_valid", i), m_valid, 1);
      chk($sformatf("vec%0d_drop", i), out_drop_count, 0);
    end

    // positive saturation, hold at the limit, then step back off it
    param_deadband = '0;
    pulse_clear();
    burst(260, 32'h7FFF_FFFF);
    repeat (2) @(negedge clk);
    chk("sat_x", m_pos_x, PMAX);
    chk("sat_frame", m_frame, 260);
    send(32'h7FFF_FFFF, 32'd0);
    chk("sat_hold_x", m_pos_x, PMAX);
    send(32'hFFFF_FFFF, 32'd0);
    chk("sat_back_x", m_pos_x, PMAX - 1);

    // stalled consumer: output held, drops counted, latest value after handshake
    pulse_clear();
    m_ready = 1'b0;
    burst(3, 32'd10);
    repeat (3) @(negedge clk);
    chk("stall_x", m_pos_x, 10);
    chk("stall_frame", m_frame, 1);
    chk("stall_drop", out_drop_count, 2);
    chk("stall_valid", m_valid, 1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("dirty_x", m_pos_x, 30);
    chk("dirty_frame", m_frame, 3);
    chk("dirty_valid", m_valid, 1);
    @(negedge clk);
    chk("done_valid", m_valid, 0);

    // clear coincident with a new sample
    pulse_clear();
    m_ready = 1'b0;
    burst(5, 32'd100);
    repeat (3) @(negedge clk);
    chk("pre_clear_drop", out_drop_count, 4);
    in_clear = 1'b1; s_of_valid = 1'b1; s_of_dx = 32'd7; s_of_dy = '0;
    @(negedge clk);
    in_clear = 1'b0; s_of_valid = 1'b0;
    chk("clear_valid", m_valid, 0);
    chk("clear_drop", out_drop_count, 0);
    @(negedge clk);
    chk("clear_x", m_pos_x, 7);
    chk("clear_frame", m_frame, 1);
    chk("clear_valid2", m_valid, 1);

    // cke freeze with a sample in flight, then async reset mid-stall
    s_of_valid = 1'b1; s_of_dx = 32'd5;
    @(negedge clk);
    s_of_valid = 1'b0; cke = 1'b0;
    repeat (3) @(negedge clk);
    chk("cke_x", m_pos_x, 7);
    chk("cke_frame", m_frame, 1);
    chk("cke_drop", out_drop_count, 0);
    chk("cke_valid", m_valid, 1);
    cke = 1'b1;
    @(negedge clk);
    chk("cke_resume_drop", out_drop_count, 1);
    chk("cke_resume_x", m_pos_x, 7);
    #2 reset = 1'b1;
    #1;
    chk("areset_x", m_pos_x, 0);
    chk("areset_frame", m_frame, 0);
    chk("areset_valid", m_valid, 0);
    chk("areset_drop", out_drop_count, 0);
    @(negedge clk);
    reset = 1'b0;
    send(32'd3, 32'd0);
    chk("post_reset_x", m_pos_x, 3);
    chk("post_reset_frame", m_frame, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
